pn_share_arbiter: RTL and testbench

//  Shares one 8-bit PN (LFSR) source among NUM_REQ neuron/weight-init requesters.

---
 rtl/pn_arb_pkg.sv | 21 ++
 rtl/pn_lfsr_core.sv | 38 +++
 rtl/pn_share_arbiter.sv | 138 +++++++++++++
 tb/tb_pn_share_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_arb_pkg.sv
// Shared widths, defaults, FSM encoding and LFSR step function for the PN share arbiter.
package pn_arb_pkg;

    localparam int LFSR_W = 8;
    localparam int RAND_W = 9;
    localparam int CNT_W  = 16;

    localparam logic [LFSR_W-1:0] DEF_SEED   = 8'h37;
    localparam logic [RAND_W-1:0] DEF_OFFSET = 9'h100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Right shift with feedback tapped from bits 7, 6 and 0 into the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[6] ^ s[7] ^ s[0], s[7:1]};
    endfunction

endpackage

// File: rtl/pn_lfsr_core.sv
// 8-bit LFSR that only advances when stepped; a load overrides a step, and the
// all-zero lockup state is replaced by the seed.
module pn_lfsr_core
    import pn_arb_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (load_val_i == '0) ? SEED : load_val_i;
        end else if (step_i) begin
            lfsr_d = (lfsr_q == '0) ? SEED : lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pn_share_arbiter.sv
// Round-robin share of one PN source: each grant carries one draw, then the LFSR steps.
// Optional draw counter port enabled by defining PN_ARB_STATS_EN.
module pn_share_arbiter
    import pn_arb_pkg::*;
#(
    parameter int                NUM_REQ = 4,
    parameter logic [LFSR_W-1:0] SEED    = DEF_SEED,
    parameter logic [RAND_W-1:0] OFFSET  = DEF_OFFSET
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic [RAND_W-1:0]  rand_data,
    output logic               busy
`ifdef PN_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   draw_count
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    // Handshake: req[i] stays high until gnt[i] is seen; gnt[i] is a one-cycle
    // pulse with rand_data valid in the same cycle, and req[i] drops the cycle after.

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [RAND_W-1:0]   rand_q, rand_d;
    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic                grant_fire;
    logic                lfsr_step;
    logic [LFSR_W-1:0]   lfsr;

    pn_lfsr_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .step_i     (lfsr_step),
        .load_i     (seed_load),
        .load_val_i (seed_in),
        .lfsr_o     (lfsr)
    );

    // Search starts just past the last grantee so it becomes lowest priority.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!pick_valid && req[PTR_W'(idx)]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Requests are only looked at in IDLE, so a req still high during GRANT cannot double-grant.
    always_comb begin
        gnt_d      = '0;
        rand_d     = '0;
        ptr_d      = ptr_q;
        lfsr_step  = 1'b0;
        grant_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_fire      = 1'b1;
                    gnt_d[pick_idx] = 1'b1;
                    rand_d          = OFFSET + {1'b0, lfsr};
                    ptr_d           = pick_idx;
                end
            end
            ST_GRANT: begin
                lfsr_step = 1'b1;
            end
            default: begin
                lfsr_step = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q  <= '0;
            rand_q <= '0;
            ptr_q  <= PTR_RST;
        end else begin
            gnt_q  <= gnt_d;
            rand_q <= rand_d;
            ptr_q  <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign rand_data = rand_q;
    assign busy      = (state_q == ST_GRANT);

`ifdef PN_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (grant_fire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign draw_count = cnt_q;
`endif

endmodule

// File: tb/tb_pn_share_arbiter.sv
// Directed bench for pn_share_arbiter with hand-computed grant/draw sequences.
module tb_pn_share_arbiter;
    import pn_arb_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       seed_load;
    logic [7:0] seed_in;
    logic [3:0] gnt;
    logic [8:0] rand_data;
    logic       busy;
`ifdef PN_ARB_STATS_EN
    logic [15:0] draw_count;
`endif

    int vectors;
    int miscompares;

    pn_share_arbiter #(
        .NUM_REQ (4),
        .SEED    (8'h37),
        .OFFSET  (9'h100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .gnt        (gnt),
        .rand_data  (rand_data),
        .busy       (busy)
`ifdef PN_ARB_STATS_EN
        ,
        .draw_count (draw_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req       = '0;
        seed_load = 1'b0;
        seed_in   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Sole requester: three draws 0x137, 0x19B, 0x14D, one every two cycles.
    task automatic test_reset();
        logic [8:0] exp_r[3];
        exp_r[0] = 9'h137; exp_r[1] = 9'h19B; exp_r[2] = 9'h14D;
        reset = 1'b1; req = '0; seed_load = 1'b0; seed_in = '0;
        #2;
        vectors++;
        if (gnt !== 4'b0000 || rand_data !== 9'h000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got gnt=%b rand=%h busy=%b exp gnt=0000 rand=000 busy=0", gnt, rand_data, busy);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req = 4'b0001;
            tick();
            vectors++;
            if (gnt !== 4'b0001 || rand_data !== exp_r[i] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL sole_grant%0d got gnt=%b rand=%h busy=%b exp gnt=0001 rand=%h busy=1", i, gnt, rand_data, busy, exp_r[i]);
            end
            req = 4'b0000;
            tick();
            vectors++;
            if (gnt !== 4'b0000 || rand_data !== 9'h000 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL sole_exit%0d got gnt=%b rand=%h busy=%b exp gnt=0000 rand=000 busy=0", i, gnt, rand_data, busy);
            end
        end
    endtask

    // All four held: grants rotate 0,1,2,3,0 on odd cycles, no grant on even cycles.
    task automatic test_round_robin();
        logic [3:0] exp_g[5];
        logic [8:0] exp_r[5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_r[0] = 9'h137;  exp_r[1] = 9'h19B;  exp_r[2] = 9'h14D;  exp_r[3] = 9'h126;  exp_r[4] = 9'h113;
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (gnt !== exp_g[i] || rand_data !== exp_r[i]) begin
                miscompares++;
                $display("FAIL rr_grant%0d got gnt=%b rand=%h exp gnt=%b rand=%h", i, gnt, rand_data, exp_g[i], exp_r[i]);
            end
            tick();
            vectors++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_gap%0d got gnt=%b busy=%b exp gnt=0000 busy=0", i, gnt, busy);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    // Zero seed falls back to 0x37; a nonzero seed is taken as is.
    task automatic test_seed_load();
        apply_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        seed_load = 1'b1; seed_in = 8'h00;
        tick();
        seed_load = 1'b0;
        req = 4'b0001;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || rand_data !== 9'h137) begin
            miscompares++;
            $display("FAIL seed_zero got gnt=%b rand=%h exp gnt=0001 rand=137", gnt, rand_data);
        end
        req = 4'b0000;
        tick();
        seed_load = 1'b1; seed_in = 8'hA5;
        tick();
        seed_load = 1'b0;
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL seed_idle got gnt=%b busy=%b exp gnt=0000 busy=0", gnt, busy);
        end
        req = 4'b0001;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || rand_data !== 9'h1A5) begin
            miscompares++;
            $display("FAIL seed_a5 got gnt=%b rand=%h exp gnt=0001 rand=1a5", gnt, rand_data);
        end
        req = 4'b0000;
        tick();
    endtask

    // Load during GRANT: the grant shows the old draw (0x152), the load beats the step.
    task automatic test_seed_on_grant();
        req = 4'b0001;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || rand_data !== 9'h152) begin
            miscompares++;
            $display("FAIL load_grant_old got gnt=%b rand=%h exp gnt=0001 rand=152", gnt, rand_data);
        end
        req = 4'b0000; seed_load = 1'b1; seed_in = 8'h5A;
        tick();
        seed_load = 1'b0;
        req = 4'b0001;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || rand_data !== 9'h15A) begin
            miscompares++;
            $display("FAIL load_grant_new got gnt=%b rand=%h exp gnt=0001 rand=15a", gnt, rand_data);
        end
        req = 4'b0000;
        tick();
    endtask

    // Reset mid-GRANT drops outputs at once; pointer returns to 3 so req0 beats req3.
    task automatic test_reset_mid_grant();
        req = 4'b0100;
        tick();
        vectors++;
        if (gnt !== 4'b0100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_grant_pre got gnt=%b busy=%b exp gnt=0100 busy=1", gnt, busy);
        end
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        vectors++;
        if (gnt !== 4'b0000 || rand_data !== 9'h000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_grant_async got gnt=%b rand=%h busy=%b exp gnt=0000 rand=000 busy=0", gnt, rand_data, busy);
        end
        tick();
        reset = 1'b0;
        req   = 4'b1001;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || rand_data !== 9'h137) begin
            miscompares++;
            $display("FAIL mid_grant_after got gnt=%b rand=%h exp gnt=0001 rand=137", gnt, rand_data);
        end
        req = 4'b0000;
        tick();
    endtask

`ifdef PN_ARB_STATS_EN
    task automatic test_draw_count();
        apply_reset();
        vectors++;
        if (draw_count !== 16'd0) begin
            miscompares++;
            $display("FAIL count_reset got %0d exp 0", draw_count);
        end
        req = 4'b1111;
        for (int i = 0; i < 300; i++) begin
            tick();
            tick();
        end
        req = 4'b0000;
        tick();
        vectors++;
        if (draw_count !== 16'd300) begin
            miscompares++;
            $display("FAIL count_300 got %0d exp 300", draw_count);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_round_robin();
        test_seed_load();
        test_seed_on_grant();
        test_reset_mid_grant();
`ifdef PN_ARB_STATS_EN
        test_draw_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
